axil_csr_regfile: RTL and testbench
===================================

Name: axil_csr_regfile

Overview:
Parametrised AXI4-Lite CSR register file, the next-generation CSR block for BAR/CSR space. It adds per-register access modes (RW, RO, W1C), SLVERR on illegal accesses, and byte-strobe writes. It also exposes a hardware-side interface: register outputs, RO inputs, sticky-status set inputs and access pulses. It sits between the AXI-Lite interconnect and device control/status logic.

Parameters:
ADDR_WIDTH, 16, AXI-Lite address width
DATA_WIDTH, 32, data width; 32 or 64
NUM_REGS, 16, number of registers; 1..256
RO_MASK, {NUM_REGS{1'b0}}, bit i=1: register i is read-only, value sourced from hw_ro_data
W1C_MASK, {NUM_REGS{1'b0}}, bit i=1: register i is write-1-to-clear, bits set by hw_set
RESET_VAL, {NUM_REGS*DATA_WIDTH{1'b0}}, flattened reset value per register; reg i at [i*DATA_WIDTH +: DATA_WIDTH]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axil_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel
s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
s_axil_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel
s_axil_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
hw_ro_data  in  NUM_REGS*DATA_WIDTH  live values for RO registers
hw_set  in  NUM_REGS*DATA_WIDTH  per-bit set for W1C registers; ignored elsewhere
reg_out  out  NUM_REGS*DATA_WIDTH  current stored value of every RW/W1C register; RO slots read 0
wr_pulse  out  NUM_REGS  one-cycle strobe on a committed OKAY write to register i
rd_pulse  out  NUM_REGS  one-cycle strobe on an accepted OKAY read of register i

Behaviour:
- Reset (sync, rst=1 at edge): all ready/valid outputs=0; bresp=rresp=0; rdata=0; pulses=0; registers load RESET_VAL; pending AW/W holding state and in-flight responses are discarded.
- Decode: LSB=log2(DATA_WIDTH/8); idx=addr>>LSB. Low LSB bits are ignored. idx>=NUM_REGS is illegal.
- Write channel: AW and W are accepted independently into one-entry holding registers. awready=!aw_held&&!bvalid; wready=!w_held&&!bvalid (registered).
- Write commit: occurs in the cycle both are held, or both handshake in the same cycle. It updates the register and asserts bvalid one cycle after the later of the two handshakes. bvalid holds until bready; holding registers clear at commit.
- Write modes: RW: byte j updated where wstrb[j]. W1C: bit cleared where wdata=1 within strobed bytes. RO or illegal idx: no update, bresp=SLVERR (2'b10), no wr_pulse. Otherwise bresp=OKAY.
- W1C set/clear in the same cycle: hw_set wins, so the bit ends at 1. hw_set applies every cycle independent of the bus.
- Read channel: arready=!rvalid&&!ar_pending. Handshake at cycle N gives rvalid/rdata/rresp at N+1. rdata and rresp are stable until rready.
- Read sources: RW/W1C read the stored value; RO reads hw_ro_data sampled at the handshake edge.
- Illegal read: rdata=0, rresp=SLVERR, no rd_pulse.
- rd_pulse asserts in the cycle after the AR handshake.
- Read and write to the same register in the same cycle: the read returns the pre-write value.
- Back-to-back: a new AR is accepted the cycle after rvalid&&rready, giving a max read rate of 1 per 2 cycles. Writes follow the same rate.
- Read and write channels are fully independent; there is no ordering between them.

Test Plan:
- Reset with RESET_VAL reg2=0x0000_00A5 -> read idx2 returns 0xA5 OKAY; reg_out slot2=0xA5; all valids 0 during/after reset.
- AW@0x8 at cycle 0, W 0x1234_5678 strb=4'b0011 at cycle 3 (reg2=0xA5) -> bvalid at cycle 4, reg2=0x0000_5678, wr_pulse[2] for 1 cycle.
- W1C reg5 (W1C_MASK bit5) = 0xF: write 0x3 -> reg5=0xC. Same-cycle hw_set bit0 with write 0x1 -> bit0 stays 1.
- RO reg1, hw_ro_data slot1=0xDEAD_BEEF -> read returns 0xDEADBEEF OKAY. Write to reg1 -> bresp=SLVERR, value unchanged, no wr_pulse.
- Read/write at idx=NUM_REGS (0x40) -> rresp/bresp=SLVERR, rdata=0, no pulses, no register change.
- rready held low 5 cycles with rvalid=1 -> rdata stable and arready=0 throughout. Asserting rst mid-transaction -> rvalid/bvalid drop next cycle, holding state cleared.

Source files
------------

// File: rtl/axil_csr_regfile.sv
// axil_csr_regfile
//   AXI4-Lite CSR register file with per-register access modes.
//   RW registers take byte-strobed writes. RO registers return live hw_ro_data.
//   W1C registers clear bits on written ones and are set by hw_set.
//   Illegal writes (RO or out-of-range index) and out-of-range reads get SLVERR.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   s_axil_aw*/w*/b*              AXI-Lite write address / data / response channels
//   s_axil_ar*/r*                 AXI-Lite read address / data channels
//   hw_ro_data  [NUM_REGS*DW]     live values for RO slots
//   hw_set      [NUM_REGS*DW]     per-bit sticky set for W1C slots
//   reg_out     [NUM_REGS*DW]     stored value of each RW/W1C slot (RO slots are 0)
//   wr_pulse    [NUM_REGS]        one-cycle strobe on each committed OKAY write
//   rd_pulse    [NUM_REGS]        one-cycle strobe after each accepted OKAY read

// One storage cell. Its access mode is fixed at elaboration.
module axil_csr_cell #(
    parameter int                    DATA_WIDTH = 32,
    parameter bit                    IS_RO      = 1'b0,
    parameter bit                    IS_W1C     = 1'b0,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [DATA_WIDTH-1:0]   hw_ro,
    input  logic [DATA_WIDTH-1:0]   hw_set,
    output logic [DATA_WIDTH-1:0]   q_out,
    output logic [DATA_WIDTH-1:0]   rd_val
);
    logic [DATA_WIDTH-1:0] bmask;

    for (genvar j = 0; j < DATA_WIDTH/8; j++) begin : g_bm
        assign bmask[j*8 +: 8] = {8{wstrb[j]}};
    end

    if (IS_RO) begin : g_ro
        logic unused_ro;
        assign unused_ro = ^{clk, rst, we, wdata, bmask, hw_set};
        assign q_out  = '0;
        assign rd_val = hw_ro;
    end else begin : g_st
        logic [DATA_WIDTH-1:0] q;
        if (IS_W1C) begin : g_w1c
            logic unused_w1c;
            assign unused_w1c = ^hw_ro;
            // hw_set is OR'ed in after the clear, so a set in the same cycle wins.
            always_ff @(posedge clk) begin
                if (rst) q <= RST_VAL;
                else     q <= (q & ~(we ? (wdata & bmask) : '0)) | hw_set;
            end
        end else begin : g_rw
            logic unused_rw;
            assign unused_rw = ^{hw_ro, hw_set};
            always_ff @(posedge clk) begin
                if (rst)     q <= RST_VAL;
                else if (we) q <= (q & ~bmask) | (wdata & bmask);
            end
        end
        assign q_out  = q;
        assign rd_val = q;
    end
endmodule

module axil_csr_regfile #(
    parameter int                             ADDR_WIDTH = 16,
    parameter int                             DATA_WIDTH = 32,
    parameter int                             NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0]            W1C_MASK   = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    output logic [DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);
    localparam int         STRB_W      = DATA_WIDTH/8;
    localparam int         LSB         = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]     strb;
    } wr_data_t;

    // One-hot register select; all zeros means the index is out of range.
    function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] idx;
        decode = '0;
        idx    = addr >> LSB;
        for (int i = 0; i < NUM_REGS; i++) decode[i] = (idx == ADDR_WIDTH'(i));
    endfunction

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] cell_q, cell_rd;
    logic [NUM_REGS-1:0]                 we;

    // Write-side holding state
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    wr_data_t              w_q;

    logic                  aw_fire, w_fire, commit, wr_ok;
    logic                  aw_held_n, w_held_n, bvalid_n;
    logic [ADDR_WIDTH-1:0] aw_addr_eff;
    wr_data_t              w_eff;
    logic [NUM_REGS-1:0]   wr_hit;

    logic                  ar_fire, rd_ok, rvalid_n;
    logic [NUM_REGS-1:0]   ar_hit;
    logic [DATA_WIDTH-1:0] rd_mux;

    always_comb begin
        aw_fire     = s_axil_awvalid && s_axil_awready;
        w_fire      = s_axil_wvalid && s_axil_wready;
        // Commit as soon as both halves are present, held or arriving now.
        commit      = (aw_held || aw_fire) && (w_held || w_fire);
        aw_addr_eff = aw_held ? aw_addr_q : s_axil_awaddr;
        w_eff       = w_held ? w_q : '{data: s_axil_wdata, strb: s_axil_wstrb};
        wr_hit      = decode(aw_addr_eff);
        wr_ok       = |(wr_hit & ~RO_MASK);
        we          = {NUM_REGS{commit && wr_ok}} & wr_hit;
        aw_held_n   = !commit && (aw_held || aw_fire);
        w_held_n    = !commit && (w_held || w_fire);
        bvalid_n    = commit || (s_axil_bvalid && !s_axil_bready);

        ar_fire     = s_axil_arvalid && s_axil_arready;
        ar_hit      = decode(s_axil_araddr);
        rd_ok       = |ar_hit;
        rvalid_n    = ar_fire || (s_axil_rvalid && !s_axil_rready);
        rd_mux      = '0;
        for (int i = 0; i < NUM_REGS; i++) if (ar_hit[i]) rd_mux = cell_rd[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_addr_q      <= '0;
            w_q            <= '0;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= RESP_OKAY;
            wr_pulse       <= '0;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rresp   <= RESP_OKAY;
            s_axil_rdata   <= '0;
            rd_pulse       <= '0;
        end else begin
            aw_held <= aw_held_n;
            w_held  <= w_held_n;
            if (aw_fire) aw_addr_q <= s_axil_awaddr;
            if (w_fire)  w_q <= '{data: s_axil_wdata, strb: s_axil_wstrb};
            // Readies are registered copies of the next-cycle acceptance condition.
            s_axil_awready <= !aw_held_n && !bvalid_n;
            s_axil_wready  <= !w_held_n && !bvalid_n;
            s_axil_bvalid  <= bvalid_n;
            if (commit) s_axil_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            wr_pulse       <= we;

            s_axil_arready <= !rvalid_n;
            s_axil_rvalid  <= rvalid_n;
            // Sampled before this edge's write lands, so a colliding read sees the old value.
            if (ar_fire) begin
                s_axil_rdata <= rd_ok ? rd_mux : '0;
                s_axil_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            rd_pulse <= ar_fire ? ar_hit : '0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        axil_csr_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .IS_RO      (RO_MASK[i]),
            .IS_W1C     (W1C_MASK[i] && !RO_MASK[i]),
            .RST_VAL    (RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH])
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .we     (we[i]),
            .wdata  (w_eff.data),
            .wstrb  (w_eff.strb),
            .hw_ro  (hw_ro_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .hw_set (hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
            .q_out  (cell_q[i]),
            .rd_val (cell_rd[i])
        );
    end

    assign reg_out = cell_q;
endmodule

// File: tb/tb_axil_csr_regfile.sv
module tb_axil_csr_regfile;
    localparam int AW = 16, DW = 32, NR = 16;
    localparam logic [NR-1:0]    RO_M  = 16'h0002;
    localparam logic [NR-1:0]    W1C_M = 16'h0020;
    localparam logic [NR*DW-1:0] RV    = (512'h0F << (5*32)) | (512'hA5 << (2*32));
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] awaddr, araddr;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [NR*DW-1:0] hw_ro_data, hw_set, reg_out;
    logic [NR-1:0] wr_pulse, rd_pulse;

    always #5 clk = ~clk;

    axil_csr_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
        .RO_MASK(RO_M), .W1C_MASK(W1C_M), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .hw_ro_data(hw_ro_data), .hw_set(hw_set), .reg_out(reg_out),
        .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [15:0] exp_pulse;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t      rd_q[$];
    logic [1:0] wr_q[$];
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] slot(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_resp, output logic [15:0] pulse);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int n = 0;
        logic [1:0] e;
        wr_q.push_back(exp_resp);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(aw_done && w_done) && n < 40) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            tick(); n++;
            if (aw_now) begin awvalid = 0; aw_done = 1; end
            if (w_now)  begin wvalid = 0;  w_done = 1;  end
        end
        awvalid = 0; wvalid = 0;
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
        n = 0;
        while (!bvalid && n < 40) begin tick(); n++; end
        chk("bvalid_seen", bvalid, 1);
        pulse = wr_pulse;
        if (bvalid && wr_q.size() > 0) begin
            e = wr_q.pop_front();
            chk("bresp", bresp, e);
        end
        tick();
    endtask

    task automatic do_read(input logic [15:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                           output logic [15:0] pulse);
        int n = 0;
        rexp_t e;
        rd_q.push_back('{exp_d, exp_r});
        araddr = a; arvalid = 1;
        while (!arready && n < 40) begin tick(); n++; end
        chk("arready_seen", arready, 1);
        tick();
        arvalid = 0;
        chk("rvalid_next", rvalid, 1);
        pulse = rd_pulse;
        if (rvalid && rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk("rdata", rdata, e.data);
            chk("rresp", rresp, e.resp);
        end
        tick();
    endtask

    vec_t vt[13];

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] p;
        logic [1:0]  eb;
        rexp_t       er;

        vt[0]  = '{1'b0, 16'h0008, 32'h0,        4'h0, 32'h0000_00A5, OKAY,   16'h0004};
        vt[1]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'hDEAD_BEEF, OKAY,   16'h0002};
        vt[2]  = '{1'b1, 16'h0004, 32'h1,        4'hF, 32'h0,         SLVERR, 16'h0000};
        vt[3]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'hDEAD_BEEF, OKAY,   16'h0002};
        vt[4]  = '{1'b1, 16'h0014, 32'h3,        4'hF, 32'h0,         OKAY,   16'h0020};
        vt[5]  = '{1'b0, 16'h0014, 32'h0,        4'h0, 32'h0000_000C, OKAY,   16'h0020};
        vt[6]  = '{1'b1, 16'h0040, 32'hFFFF,     4'hF, 32'h0,         SLVERR, 16'h0000};
        vt[7]  = '{1'b0, 16'h0040, 32'h0,        4'h0, 32'h0,         SLVERR, 16'h0000};
        vt[8]  = '{1'b1, 16'h000C, 32'hAABBCCDD, 4'hA, 32'h0,         OKAY,   16'h0008};
        vt[9]  = '{1'b0, 16'h000E, 32'h0,        4'h0, 32'hAA00_CC00, OKAY,   16'h0008};
        vt[10] = '{1'b1, 16'h003C, 32'hFFFFFFFF, 4'hF, 32'h0,         OKAY,   16'h8000};
        vt[11] = '{1'b0, 16'h003C, 32'h0,        4'h0, 32'hFFFF_FFFF, OKAY,   16'h8000};
        vt[12] = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0,         OKAY,   16'h0001};

        rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 1;
        araddr = 0; arvalid = 0; rready = 1; hw_set = '0;
        for (int i = 0; i < NR; i++) hw_ro_data[i*32 +: 32] = 32'h1000_0000 + i;
        hw_ro_data[1*32 +: 32] = 32'hDEAD_BEEF;

        // Reset state
        tick(); tick();
        chk("rst_ready", {awready, wready, arready}, 3'b000);
        chk("rst_valid", {bvalid, rvalid}, 2'b00);
        chk("rst_pulses", {wr_pulse, rd_pulse}, 32'h0);
        chk("rst_reg2", slot(2), 32'hA5);
        chk("rst_reg5", slot(5), 32'hF);
        rst = 0;
        tick();
        chk("post_rst_ready", {awready, wready, arready}, 3'b111);

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            if (vt[i].is_wr) do_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].exp_resp, p);
            else             do_read(vt[i].addr, vt[i].exp_data, vt[i].exp_resp, p);
            chk($sformatf("v%0d_pulse", i), p, vt[i].exp_pulse);
        end
        chk("ro_slot_zero", slot(1), 32'h0);
        chk("w1c_reg5", slot(5), 32'hC);
        chk("strb_reg3", slot(3), 32'hAA00_CC00);
        chk("illegal_no_alias", slot(0), 32'h0);

        // Staggered AW then W
        wr_q.push_back(OKAY);
        awaddr = 16'h0008; awvalid = 1;
        chk("stag_awready", awready, 1);
        tick(); awvalid = 0;
        chk("stag_aw_held", awready, 0);
        for (int k = 0; k < 2; k++) begin
            chk("stag_no_bvalid", bvalid, 0);
            tick();
        end
        wdata = 32'h1234_5678; wstrb = 4'b0011; wvalid = 1;
        chk("stag_wready", wready, 1);
        tick(); wvalid = 0;
        chk("stag_bvalid", bvalid, 1);
        chk("stag_reg2", slot(2), 32'h0000_5678);
        chk("stag_pulse", wr_pulse, 16'h0004);
        eb = wr_q.pop_front();
        chk("stag_bresp", bresp, eb);
        tick();
        chk("stag_pulse_gone", wr_pulse, 16'h0);
        chk("stag_bvalid_gone", bvalid, 0);

        // W1C with same-cycle hw_set
        hw_set[5*32 +: 32] = 32'h1;
        tick();
        hw_set[5*32 +: 32] = 32'h0;
        chk("hwset_reg5", slot(5), 32'hD);
        chk("w1c_idle", {awready, wready}, 2'b11);
        wr_q.push_back(OKAY);
        awaddr = 16'h0014; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        hw_set[5*32 +: 32] = 32'h1;
        tick();
        awvalid = 0; wvalid = 0; hw_set[5*32 +: 32] = 32'h0;
        chk("w1c_set_bvalid", bvalid, 1);
        eb = wr_q.pop_front();
        chk("w1c_set_bresp", bresp, eb);
        chk("w1c_set_wins", slot(5), 32'hD);
        tick();
        do_write(16'h0014, 32'h1, 4'hF, OKAY, p);
        chk("w1c_clear_bit0", slot(5), 32'hC);

        // rready held low
        rready = 0;
        rd_q.push_back('{32'h0000_5678, OKAY});
        araddr = 16'h0008; arvalid = 1;
        chk("hold_arready", arready, 1);
        tick(); arvalid = 0;
        er = rd_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk("hold_rvalid", rvalid, 1);
            chk("hold_rdata", rdata, er.data);
            chk("hold_rresp", rresp, er.resp);
            chk("hold_arready_low", arready, 0);
            tick();
        end
        rready = 1;
        tick();
        chk("hold_released", rvalid, 0);
        tick();

        // Read and write of the same register in one cycle
        rd_q.push_back('{32'hFFFF_FFFF, OKAY});
        wr_q.push_back(OKAY);
        araddr = 16'h003C; arvalid = 1;
        awaddr = 16'h003C; wdata = 32'h0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        chk("rw_idle", {arready, awready, wready}, 3'b111);
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        er = rd_q.pop_front();
        chk("rw_rdata_old", rdata, er.data);
        eb = wr_q.pop_front();
        chk("rw_bresp", bresp, eb);
        chk("rw_reg15_new", slot(15), 32'h0);
        tick();

        // Reset with responses in flight
        rready = 0; bready = 0;
        araddr = 16'h0008; arvalid = 1;
        awaddr = 16'h0000; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        chk("inflight_valids", {rvalid, bvalid}, 2'b11);
        rst = 1;
        tick();
        chk("rst_mid_valids", {rvalid, bvalid}, 2'b00);
        chk("rst_mid_ready", {awready, wready, arready}, 3'b000);
        tick();
        chk("rst_mid_reg2", slot(2), 32'hA5);
        chk("rst_mid_reg0", slot(0), 32'h0);
        rst = 0; rready = 1; bready = 1;
        tick();

        // Held AW is discarded by reset
        awaddr = 16'h0010; awvalid = 1;
        chk("drop_awready", awready, 1);
        tick(); awvalid = 0;
        rst = 1; tick(); rst = 0; tick();
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
        chk("drop_wready", wready, 1);
        tick(); wvalid = 0;
        for (int k = 0; k < 3; k++) begin
            chk("drop_no_commit", bvalid, 0);
            tick();
        end
        awaddr = 16'h0010; awvalid = 1;
        tick(); awvalid = 0;
        chk("drop_commit", bvalid, 1);
        chk("drop_bresp", bresp, OKAY);
        chk("drop_reg4", slot(4), 32'h77);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
